// File: rtl/debounce_pkg.sv
// Shared types, width helpers and default timing for the button debouncer bank.
// Defaults assume d_clk is a 50 MHz-derived tick (50000 cycles ~ 1 ms at 50 MHz).
package debounce_pkg;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_e;

    localparam int DEF_NUM_CH       = 5;
    localparam int DEF_STABLE_CNT   = 50000;
    localparam int DEF_REPEAT_DELAY = 500000;
    localparam int DEF_REPEAT_RATE  = 100000;

    // Bits needed to hold 0..max_val; never less than 1.
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchroniser, stability counter, clean level with
// rise/fall pulses, and an optional hold-to-repeat press generator.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int STABLE_CNT   = DEF_STABLE_CNT,
    parameter bit INV          = 1'b0,
    parameter bit RPT_EN       = 1'b0,
    parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
    input  logic d_clk,
    input  logic reset_n,
    input  logic btn_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic press_o
);

    localparam int CW = cnt_w(STABLE_CNT);
    localparam int RW = cnt_w(max_int(REPEAT_DELAY, REPEAT_RATE));

    localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_CNT - 1);
    localparam logic [RW-1:0] DLY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RATE_LAST = RW'(REPEAT_RATE - 1);

    logic          s1_q, s2_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic          press_q, press_d;
    rpt_state_e    st_q, st_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic          stable_done;
    logic          rpt_pulse;

    // Stability counter: any sample matching the current level restarts the count.
    always_comb begin
        cnt_d       = cnt_q;
        level_d     = level_q;
        stable_done = (s2_q != level_q) && (cnt_q == CNT_LAST);
        if (s2_q == level_q) begin
            cnt_d = '0;
        end else if (stable_done) begin
            level_d = s2_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
        rise_d = stable_done &  s2_q;
        fall_d = stable_done & ~s2_q;
    end

    // Repeat FSM keys off the same-cycle rise/fall so press lines up with rise,
    // and a fall always beats a coincident repeat terminal count.
    always_comb begin
        st_d      = st_q;
        rcnt_d    = rcnt_q;
        rpt_pulse = 1'b0;
        if (!RPT_EN) begin
            st_d   = RPT_IDLE;
            rcnt_d = '0;
        end else begin
            case (st_q)
                RPT_IDLE: begin
                    if (rise_d) begin
                        st_d   = RPT_DELAY;
                        rcnt_d = '0;
                    end
                end
                RPT_DELAY: begin
                    if (fall_d) begin
                        st_d   = RPT_IDLE;
                        rcnt_d = '0;
                    end else if (rcnt_q == DLY_LAST) begin
                        rpt_pulse = 1'b1;
                        rcnt_d    = '0;
                        st_d      = RPT_REPEAT;
                    end else begin
                        rcnt_d = rcnt_q + RW'(1);
                    end
                end
                RPT_REPEAT: begin
                    if (fall_d) begin
                        st_d   = RPT_IDLE;
                        rcnt_d = '0;
                    end else if (rcnt_q == RATE_LAST) begin
                        rpt_pulse = 1'b1;
                        rcnt_d    = '0;
                    end else begin
                        rcnt_d = rcnt_q + RW'(1);
                    end
                end
                default: begin
                    st_d   = RPT_IDLE;
                    rcnt_d = '0;
                end
            endcase
        end
        press_d = rise_d | rpt_pulse;
    end

    always_ff @(posedge d_clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            press_q <= 1'b0;
            st_q    <= RPT_IDLE;
            rcnt_q  <= '0;
        end else begin
            s1_q    <= btn_i ^ INV;
            s2_q    <= s1_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            press_q <= press_d;
            st_q    <= st_d;
            rcnt_q  <= rcnt_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;
    assign press_o = press_q;

endmodule

// File: rtl/debounce_bank.sv
// N-channel push-button conditioner; each channel is an independent
// debounce_channel with its own inversion and auto-repeat enable.
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int                NUM_CH       = DEF_NUM_CH,
    parameter int                STABLE_CNT   = DEF_STABLE_CNT,
    parameter logic [NUM_CH-1:0] IN_INV       = '0,
    parameter logic [NUM_CH-1:0] REPEAT_MASK  = '0,
    parameter int                REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int                REPEAT_RATE  = DEF_REPEAT_RATE
) (
    input  logic              d_clk,
    input  logic              reset_n,
    input  logic [NUM_CH-1:0] btn_in,
    output logic [NUM_CH-1:0] level,
    output logic [NUM_CH-1:0] rise,
    output logic [NUM_CH-1:0] fall,
    output logic [NUM_CH-1:0] press
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        debounce_channel #(
            .STABLE_CNT  (STABLE_CNT),
            .INV         (IN_INV[i]),
            .RPT_EN      (REPEAT_MASK[i]),
            .REPEAT_DELAY(REPEAT_DELAY),
            .REPEAT_RATE (REPEAT_RATE)
        ) u_ch (
            .d_clk  (d_clk),
            .reset_n(reset_n),
            .btn_i  (btn_in[i]),
            .level_o(level[i]),
            .rise_o (rise[i]),
            .fall_o (fall[i]),
            .press_o(press[i])
        );
    end

endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank: STABLE_CNT=4, REPEAT_DELAY=10, REPEAT_RATE=3,
// channel 0 auto-repeats, channel 4 is active-low.
module tb_debounce_bank;

    localparam int NUM_CH = 5;

    logic              d_clk = 1'b0;
    logic              reset_n;
    logic [NUM_CH-1:0] btn_in;
    logic [NUM_CH-1:0] level, rise, fall, press;

    int n_checks = 0;
    int n_fail   = 0;

    debounce_bank #(
        .NUM_CH      (NUM_CH),
        .STABLE_CNT  (4),
        .IN_INV      (5'b10000),
        .REPEAT_MASK (5'b00001),
        .REPEAT_DELAY(10),
        .REPEAT_RATE (3)
    ) dut (
        .d_clk  (d_clk),
        .reset_n(reset_n),
        .btn_in (btn_in),
        .level  (level),
        .rise   (rise),
        .fall   (fall),
        .press  (press)
    );

    always #5 d_clk = ~d_clk;

    // Advance n rising edges; sample point is 1 time unit after the last edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge d_clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        btn_in  = 5'b10000;
        #3;
        n_checks++;
        if ({level, rise, fall, press} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 0", {level, rise, fall, press});
        end
        tick(2);
        reset_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick(1);
            n_checks++;
            if ({level, rise, fall, press} !== 20'h0) begin
                n_fail++;
                $display("FAIL post_reset_idle edge %0d: got %h want 0", e, {level, rise, fall, press});
            end
        end
    endtask

    task automatic test_clean_press();
        btn_in[1] = 1'b1;
        tick(5);
        n_checks++;
        if (level[1] !== 1'b0 || rise[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL clean_press_early: level=%b rise=%b want 0 0", level[1], rise[1]);
        end
        tick(1);
        n_checks++;
        if ({level[1], rise[1], press[1], fall[1]} !== 4'b1110) begin
            n_fail++;
            $display("FAIL clean_press_edge6: lvl/rise/press/fall=%b want 1110",
                     {level[1], rise[1], press[1], fall[1]});
        end
        tick(1);
        n_checks++;
        if ({level[1], rise[1], press[1]} !== 3'b100) begin
            n_fail++;
            $display("FAIL clean_press_one_cycle: lvl/rise/press=%b want 100", {level[1], rise[1], press[1]});
        end
        btn_in[1] = 1'b0;
        tick(5);
        n_checks++;
        if ({level[1], fall[1]} !== 2'b10) begin
            n_fail++;
            $display("FAIL clean_release_early: lvl/fall=%b want 10", {level[1], fall[1]});
        end
        tick(1);
        n_checks++;
        if ({level[1], fall[1], rise[1]} !== 3'b010) begin
            n_fail++;
            $display("FAIL clean_release_edge6: lvl/fall/rise=%b want 010", {level[1], fall[1], rise[1]});
        end
        tick(1);
        n_checks++;
        if (fall[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL clean_release_one_cycle: fall=%b want 0", fall[1]);
        end
    endtask

    task automatic test_bounce();
        logic [3:0] pat;
        pat = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            btn_in[2] = pat[k];
            for (int c = 0; c < 2; c++) begin
                tick(1);
                n_checks++;
                if ({level[2], rise[2], fall[2], press[2]} !== 4'b0000) begin
                    n_fail++;
                    $display("FAIL bounce_quiet step %0d: got %b want 0000", k,
                             {level[2], rise[2], fall[2], press[2]});
                end
            end
        end
        btn_in[2] = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            tick(1);
            n_checks++;
            if ({level[2], rise[2]} !== 2'b00) begin
                n_fail++;
                $display("FAIL bounce_settle edge %0d: lvl/rise=%b want 00", e, {level[2], rise[2]});
            end
        end
        tick(1);
        n_checks++;
        if ({level[2], rise[2]} !== 2'b11) begin
            n_fail++;
            $display("FAIL bounce_rise_edge6: lvl/rise=%b want 11", {level[2], rise[2]});
        end
        btn_in[2] = 1'b0;
        tick(8);
    endtask

    task automatic test_auto_repeat();
        int  press3;
        logic exp_p;
        press3 = 0;
        btn_in[0] = 1'b1;
        btn_in[3] = 1'b1;
        tick(6);
        for (int off = 0; off < 30; off++) begin
            if (off > 0) tick(1);
            exp_p = (off == 0) || (off >= 10 && ((off - 10) % 3) == 0);
            n_checks++;
            if (press[0] !== exp_p || rise[0] !== (off == 0)) begin
                n_fail++;
                $display("FAIL auto_repeat off %0d: press=%b rise=%b want %b %b",
                         off, press[0], rise[0], exp_p, (off == 0));
            end
            if (press[3] === 1'b1) press3++;
        end
        n_checks++;
        if (press3 != 1 || level[3] !== 1'b1) begin
            n_fail++;
            $display("FAIL masked_single_press: presses=%0d level=%b want 1 1", press3, level[3]);
        end
        btn_in[0] = 1'b0;
        btn_in[3] = 1'b0;
        tick(10);
    endtask

    task automatic test_release_terminal();
        btn_in[0] = 1'b1;
        tick(6);
        for (int off = 1; off <= 30; off++) begin
            tick(1);
            if (off == 25) btn_in[0] = 1'b0;
        end
        tick(1);
        n_checks++;
        if ({fall[0], press[0], level[0]} !== 3'b100) begin
            n_fail++;
            $display("FAIL release_on_terminal: fall/press/lvl=%b want 100", {fall[0], press[0], level[0]});
        end
        for (int e = 1; e <= 10; e++) begin
            tick(1);
            n_checks++;
            if (press[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL no_press_after_fall edge %0d: press=%b want 0", e, press[0]);
            end
        end
    endtask

    task automatic test_reset_mid();
        btn_in = 5'b10011;
        tick(6);
        n_checks++;
        if (level !== 5'b00011) begin
            n_fail++;
            $display("FAIL reset_mid_setup: level=%b want 00011", level);
        end
        btn_in[2] = 1'b1;
        tick(3);
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({level, rise, fall, press} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_mid_async: got %h want 0", {level, rise, fall, press});
        end
        tick(2);
        n_checks++;
        if ({level, rise, fall, press} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_mid_held: got %h want 0", {level, rise, fall, press});
        end
        reset_n = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            tick(1);
            n_checks++;
            if ({level, rise, fall, press} !== 20'h0) begin
                n_fail++;
                $display("FAIL reset_release_quiet edge %0d: got %h want 0", e, {level, rise, fall, press});
            end
        end
        tick(1);
        n_checks++;
        if (rise !== 5'b00111 || fall !== 5'b00000 || level !== 5'b00111 || press !== 5'b00111) begin
            n_fail++;
            $display("FAIL reset_release_rise: rise=%b fall=%b lvl=%b press=%b want 00111 00000 00111 00111",
                     rise, fall, level, press);
        end
        btn_in = 5'b10000;
        tick(10);
    endtask

    task automatic test_inversion();
        n_checks++;
        if (level[4] !== 1'b0) begin
            n_fail++;
            $display("FAIL inv_idle_level: level=%b want 0", level[4]);
        end
        btn_in[4] = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            tick(1);
            n_checks++;
            if ({level[4], rise[4]} !== 2'b00) begin
                n_fail++;
                $display("FAIL inv_early edge %0d: lvl/rise=%b want 00", e, {level[4], rise[4]});
            end
        end
        tick(1);
        n_checks++;
        if ({level[4], rise[4], press[4]} !== 3'b111) begin
            n_fail++;
            $display("FAIL inv_rise_edge6: lvl/rise/press=%b want 111", {level[4], rise[4], press[4]});
        end
        btn_in[4] = 1'b1;
        tick(8);
        n_checks++;
        if (level[4] !== 1'b0) begin
            n_fail++;
            $display("FAIL inv_release: level=%b want 0", level[4]);
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_auto_repeat();
        test_release_terminal();
        test_reset_mid();
        test_inversion();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
